// File: rtl/spy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spy_pkg
// Purpose  : Shared state encoding and width helpers for the tapped spy-path
//            time-to-digital converter.
// Revision : 1.0 - initial release
// ============================================================================
package spy_pkg;

    // Measurement sequencer states, explicitly encoded on 3 bits
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_LAUNCH  = 3'd2,
        S_CAPTURE = 3'd3,
        S_ACCUM   = 3'd4,
        S_DONE    = 3'd5
    } spyTdcState_t;

    // Bits needed to hold a thermometer count of 0..taps
    function automatic int codeWidth(input int taps);
        return $clog2(taps + 1);
    endfunction

    // Bits needed to hold the sum of 'samples' codes without wrapping
    function automatic int sumWidth(input int taps, input int samples);
        return $clog2(taps + 1) + $clog2(samples);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spy_delay_chain.sv
`default_nettype none
// ============================================================================
// Module   : spy_delay_chain
// Purpose  : Chain of STAGES inverting cells driven by the launch register,
//            tapped every STAGES/TAPS stages. Isolated so that placement
//            constraints or a timing model can stand in for it.
// Revision : 1.0 - initial release
// ============================================================================
module spy_delay_chain #(
    parameter int STAGES = 100,
    parameter int TAPS   = 16
) (
    input  logic            launch,
    output logic [TAPS-1:0] taps
);

    // Inverter cells; keep stops synthesis from collapsing the chain
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic w_in;
        (* keep = "true" *) logic w_out;
        if (i == 0) begin : g_head
            assign w_in = launch;
        end else begin : g_body
            assign w_in = g_stage[i-1].w_out;
        end
        assign w_out = ~w_in;
    end

    // Tap k observes the last stage of segment k
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        assign taps[k] = g_stage[((k + 1) * STAGES) / TAPS - 1].w_out;
    end

endmodule
`default_nettype wire

// File: rtl/spy_path_tdc.sv
`default_nettype none
// ============================================================================
// Module   : spy_path_tdc
// Purpose  : Launches a transition into a tapped spy chain, captures how far
//            it travelled in one clock period, converts it to a thermometer
//            code and sums the codes over SAMPLES launches.
// Revision : 1.0 - initial release
// ============================================================================
module spy_path_tdc
    import spy_pkg::*;
#(
    parameter int STAGES  = 100,
    parameter int TAPS    = 16,
    parameter int SAMPLES = 4,
    parameter int SETTLE  = 8
) (
    input  logic                                 clk,
    input  logic                                 resetN,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 resultValid,
    output logic [sumWidth(TAPS, SAMPLES)-1:0]   resultSum,
    output logic [codeWidth(TAPS)-1:0]           lastCode,
    output logic                                 bubbleErr
);

    localparam int c_CODE_W   = codeWidth(TAPS);
    localparam int c_SUM_W    = sumWidth(TAPS, SAMPLES);
    localparam int c_CNT_W    = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam int c_SETTLE_W = $clog2(SETTLE);

    spyTdcState_t            r_state;
    spyTdcState_t            w_nextState;
    logic                    r_launch;
    logic [TAPS-1:0]         w_taps;
    logic [TAPS-1:0]         r_baseline;
    logic [TAPS-1:0]         r_capture;
    logic [TAPS-1:0]         w_flip;
    logic [c_CODE_W-1:0]     w_code;
    logic                    w_bubble;
    logic                    w_seenZero;
    logic [c_SUM_W-1:0]      r_accum;
    logic [c_SUM_W-1:0]      w_accumNext;
    logic [c_SUM_W-1:0]      r_resultSum;
    logic [c_CODE_W-1:0]     r_lastCode;
    logic                    r_bubbleErr;
    logic [c_CNT_W-1:0]      r_sampleCnt;
    logic [c_SETTLE_W-1:0]   r_settleCnt;
    logic                    w_lastSample;

    // The launch flop drives the chain with no buffering or synchroniser
    spy_delay_chain #(
        .STAGES (STAGES),
        .TAPS   (TAPS)
    ) u_chain (
        .launch (r_launch),
        .taps   (w_taps)
    );

    assign w_flip       = r_baseline ^ r_capture;
    assign w_accumNext  = r_accum + c_SUM_W'(w_code);
    assign w_lastSample = (r_sampleCnt == c_CNT_W'(SAMPLES - 1));

    // Thermometer code from tap 0 upward; any 1 beyond the first 0 is a bubble
    always_comb begin
        w_code     = '0;
        w_bubble   = 1'b0;
        w_seenZero = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            if (!w_seenZero) begin
                if (w_flip[i]) w_code = c_CODE_W'(i + 1);
                else           w_seenZero = 1'b1;
            end else if (w_flip[i]) begin
                w_bubble = 1'b1;
            end
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= S_IDLE;
        else         r_state <= w_nextState;
    end

    // Sequencer next-state decode
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:    if (start) w_nextState = S_ARM;
            S_ARM:     if (r_settleCnt == '0) w_nextState = S_LAUNCH;
            S_LAUNCH:  w_nextState = S_CAPTURE;
            S_CAPTURE: w_nextState = S_ACCUM;
            S_ACCUM:   w_nextState = w_lastSample ? S_DONE : S_ARM;
            S_DONE:    w_nextState = S_IDLE;
            default:   w_nextState = S_IDLE;
        endcase
    end

    // Launch, sampling and accumulation datapath; launch is high during
    // CAPTURE so the capture edge lands exactly one period after the launch edge
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_launch    <= 1'b0;
            r_baseline  <= '0;
            r_capture   <= '0;
            r_accum     <= '0;
            r_resultSum <= '0;
            r_lastCode  <= '0;
            r_bubbleErr <= 1'b0;
            r_sampleCnt <= '0;
            r_settleCnt <= '0;
        end else begin
            r_launch <= (r_state == S_LAUNCH);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_accum     <= '0;
                        r_resultSum <= '0;
                        r_bubbleErr <= 1'b0;
                        r_sampleCnt <= '0;
                        r_settleCnt <= c_SETTLE_W'(SETTLE - 1);
                    end
                end
                S_ARM: begin
                    if (r_settleCnt == '0) r_baseline  <= w_taps;
                    else                   r_settleCnt <= r_settleCnt - 1'b1;
                end
                S_CAPTURE: r_capture <= w_taps;
                S_ACCUM: begin
                    r_lastCode  <= w_code;
                    r_accum     <= w_accumNext;
                    r_bubbleErr <= r_bubbleErr | w_bubble;
                    if (w_lastSample) begin
                        r_resultSum <= w_accumNext;
                    end else begin
                        r_sampleCnt <= r_sampleCnt + 1'b1;
                        r_settleCnt <= c_SETTLE_W'(SETTLE - 1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign resultValid = (r_state == S_DONE);
    assign resultSum   = r_resultSum;
    assign lastCode    = r_lastCode;
    assign bubbleErr   = r_bubbleErr;

endmodule
`default_nettype wire

// File: tb/tb_spy_path_tdc.sv
`default_nettype none
// ============================================================================
// Module   : tb_spy_path_tdc
// Purpose  : Self-checking bench for spy_path_tdc. The chain taps are
//            overridden by a model whose flipped taps are chosen per launch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spy_path_tdc;

    localparam int TAPS    = 16;
    localparam int SAMPLES = 4;
    localparam int SETTLE  = 8;
    localparam int PERIOD  = SETTLE + 3;
    localparam int DONE_AT = SAMPLES * PERIOD;
    localparam logic [TAPS-1:0] BASE = 16'hA5C3;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       resultValid;
    logic [6:0] resultSum;
    logic [4:0] lastCode;
    logic       bubbleErr;

    logic [TAPS-1:0] curMask = '0;

    int total = 0;
    int bad   = 0;

    int expCode[$];
    int expSum[$];
    int expBub[$];

    typedef struct packed {
        logic [3:0][15:0] masks;
        logic [3:0][4:0]  codes;
        logic [6:0]       sum;
        logic             bub;
    } vec_t;

    vec_t vecs [5];

    spy_path_tdc #(
        .STAGES  (96),
        .TAPS    (TAPS),
        .SAMPLES (SAMPLES),
        .SETTLE  (SETTLE)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .start       (start),
        .busy        (busy),
        .resultValid (resultValid),
        .resultSum   (resultSum),
        .lastCode    (lastCode),
        .bubbleErr   (bubbleErr)
    );

    always #5 clk = ~clk;

    // Tap model: taps sit at BASE, and the masked taps invert while launch is high
    initial force dut.w_taps = BASE;
    always @(posedge clk or negedge resetN) begin
        #1;
        force dut.w_taps = BASE ^ (dut.r_launch ? curMask : 16'h0000);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One full measurement; optionally pokes start in ARM, CAPTURE and DONE
    task automatic runMeas(input int idx, input bit pokeStarts);
        int valids;
        valids = 0;
        for (int k = 0; k < SAMPLES; k++) expCode.push_back(int'(vecs[idx].codes[k]));
        expSum.push_back(int'(vecs[idx].sum));
        expBub.push_back(int'(vecs[idx].bub));
        curMask = vecs[idx].masks[0];
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("bubble_cleared_on_start", int'(bubbleErr), 0);
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n % PERIOD == 0 && n < DONE_AT) curMask = vecs[idx].masks[n / PERIOD];
            if (resultValid) valids++;
            if (n % PERIOD == 0 && n <= DONE_AT) chk("lastCode", int'(lastCode), expCode.pop_front());
            if (n == DONE_AT) begin
                chk("resultValid_at_done", int'(resultValid), 1);
                chk("resultSum", int'(resultSum), expSum.pop_front());
                chk("bubbleErr_at_done", int'(bubbleErr), expBub[0]);
            end
            if (n > DONE_AT) chk("idle_after_done", int'(busy), 0);
            if (n == 50) begin
                chk("bubbleErr_held", int'(bubbleErr), expBub.pop_front());
                chk("resultSum_held", int'(resultSum), int'(vecs[idx].sum));
            end
            start = (pokeStarts && (n == 3 || n == 9 || n == DONE_AT)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        chk("single_resultValid", valids, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int valids;
        vecs[0].masks = {16'h001F, 16'h001F, 16'h001F, 16'h001F};
        vecs[0].codes = {5'd5, 5'd5, 5'd5, 5'd5};
        vecs[0].sum = 7'd20; vecs[0].bub = 1'b0;
        vecs[1].masks = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        vecs[1].codes = {5'd16, 5'd16, 5'd16, 5'd16};
        vecs[1].sum = 7'd64; vecs[1].bub = 1'b0;
        vecs[2].masks = {16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[2].codes = {5'd0, 5'd0, 5'd0, 5'd0};
        vecs[2].sum = 7'd0; vecs[2].bub = 1'b0;
        vecs[3].masks = {16'h0007, 16'h0007, 16'h0007, 16'h000B};
        vecs[3].codes = {5'd3, 5'd3, 5'd3, 5'd2};
        vecs[3].sum = 7'd11; vecs[3].bub = 1'b1;
        vecs[4].masks = {16'h0F0F, 16'h8000, 16'h0003, 16'h0001};
        vecs[4].codes = {5'd4, 5'd0, 5'd2, 5'd1};
        vecs[4].sum = 7'd7; vecs[4].bub = 1'b1;

        // Reset held
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", int'({busy, resultValid, resultSum, lastCode, bubbleErr}), 0);
        resetN = 1'b1;
        // Released without start: everything stays quiet
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            chk("quiet_after_reset", int'({busy, resultValid, resultSum, lastCode, bubbleErr}), 0);
        end

        // Table-driven measurements
        for (int i = 0; i < 5; i++) runMeas(i, 1'b0);

        // Starts poked outside IDLE are ignored
        runMeas(0, 1'b1);

        // Reset during CAPTURE of the second launch
        curMask = 16'h001F;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (PERIOD + SETTLE + 1) @(posedge clk);
        @(negedge clk);
        chk("launch_high_in_capture", int'(dut.r_launch), 1);
        resetN = 1'b0;
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_launch", int'(dut.r_launch), 0);
        chk("reset_resultSum", int'(resultSum), 0);
        chk("reset_lastCode", int'(lastCode), 0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        valids = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (resultValid || busy) valids++;
        end
        chk("no_activity_after_abort", valids, 0);
        runMeas(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
